// File: rtl/decode_conf_data.sv
// decode_conf_data: word-serial config frame decoder for the DDS core.
// Frame = HEAD, f_word, p_word, wave_type, TAIL; commit only on good TAIL.
module decode_conf_data #(
  parameter logic [31:0] HEAD_WORD = 32'hFFFF_FFFF,
  parameter logic [31:0] TAIL_WORD = 32'hFFFF_FFFF
) (
  input  logic        axi_clk,
  input  logic        rst,
  input  logic [31:0] conf_data,
  input  logic        dds_work_flag,
  output logic        set_flag,
  output logic        dds_en,
  output logic [31:0] f_word,
  output logic [11:0] p_word,
  output logic [1:0]  wave_type
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FREQ,
    S_PHASE,
    S_WAVE,
    S_TAIL
  } state_t;

  state_t      state_q;
  logic [31:0] f_sh_q;
  logic [11:0] p_sh_q;
  logic [1:0]  w_sh_q;
  logic [31:0] f_word_q;
  logic [11:0] p_word_q;
  logic [1:0]  wave_q;
  logic        set_q;
  logic        en_q;
  logic        cfg_valid_q;

  logic        is_head;
  logic        is_tail;

  assign is_head = (conf_data == HEAD_WORD);
  assign is_tail = (conf_data == TAIL_WORD);

  // Frame FSM, shadow capture, atomic commit and registered DDS enable.
  always_ff @(posedge axi_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      f_sh_q      <= '0;
      p_sh_q      <= '0;
      w_sh_q      <= '0;
      f_word_q    <= '0;
      p_word_q    <= '0;
      wave_q      <= '0;
      set_q       <= 1'b0;
      en_q        <= 1'b0;
      cfg_valid_q <= 1'b0;
    end else begin
      set_q <= 1'b0;
      en_q  <= dds_work_flag & cfg_valid_q;
      if (!dds_work_flag) begin
        // dropping the work flag abandons any partial frame
        state_q <= S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (is_head) state_q <= S_FREQ;
          end
          S_FREQ: begin
            f_sh_q  <= conf_data;
            state_q <= S_PHASE;
          end
          S_PHASE: begin
            p_sh_q  <= conf_data[11:0];
            state_q <= S_WAVE;
          end
          S_WAVE: begin
            w_sh_q  <= conf_data[1:0];
            state_q <= S_TAIL;
          end
          S_TAIL: begin
            if (is_tail) begin
              f_word_q    <= f_sh_q;
              p_word_q    <= p_sh_q;
              wave_q      <= w_sh_q;
              set_q       <= 1'b1;
              cfg_valid_q <= 1'b1;
            end
            // trailer is never reused as the next header
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign set_flag  = set_q;
  assign dds_en    = en_q;
  assign f_word    = f_word_q;
  assign p_word    = p_word_q;
  assign wave_type = wave_q;

endmodule

// File: tb/tb_decode_conf_data.sv
// tb_decode_conf_data: directed plus random frames against a
// frame-queue reference model, compared on every falling edge.
module tb_decode_conf_data;

  localparam logic [31:0] HEAD = 32'hFFFF_FFFF;
  localparam logic [31:0] TAIL = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] conf;
  logic        flag;
  logic        set_flag;
  logic        dds_en;
  logic [31:0] f_word;
  logic [11:0] p_word;
  logic [1:0]  wave_type;

  decode_conf_data #(.HEAD_WORD(HEAD), .TAIL_WORD(TAIL)) dut (
    .axi_clk       (clk),
    .rst           (rst),
    .conf_data     (conf),
    .dds_work_flag (flag),
    .set_flag      (set_flag),
    .dds_en        (dds_en),
    .f_word        (f_word),
    .p_word        (p_word),
    .wave_type     (wave_type)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: collect words of the frame in progress in a queue;
  // a complete 5-word frame commits when its last word is the trailer.
  logic [31:0] fq[$];
  bit          m_valid = 0;
  logic [31:0] e_f = '0;
  logic [11:0] e_p = '0;
  logic [1:0]  e_w = '0;
  bit          e_set = 0;
  bit          e_en = 0;
  bit          started = 0;

  always @(posedge clk) begin
    logic [31:0] pw;
    logic [31:0] ww;
    if (rst) begin
      fq.delete();
      m_valid = 0;
      e_f = '0;
      e_p = '0;
      e_w = '0;
      e_set = 0;
      e_en = 0;
    end else begin
      e_set = 0;
      e_en = flag && m_valid;
      if (fq.size() == 0) begin
        if (flag && conf == HEAD) fq.push_back(conf);
      end else if (!flag) begin
        fq.delete();
      end else begin
        fq.push_back(conf);
        if (fq.size() == 5) begin
          if (conf == TAIL) begin
            pw = fq[2];
            ww = fq[3];
            e_f = fq[1];
            e_p = pw[11:0];
            e_w = ww[1:0];
            e_set = 1;
            m_valid = 1;
          end
          fq.delete();
        end
      end
    end
    started = 1;
  end

  // Single compare process, every cycle once the model has seen an edge.
  always @(negedge clk) begin
    if (started) begin
      chk("set_flag", {31'd0, set_flag}, {31'd0, e_set});
      chk("dds_en", {31'd0, dds_en}, {31'd0, e_en});
      chk("f_word", f_word, e_f);
      chk("p_word", {20'd0, p_word}, {20'd0, e_p});
      chk("wave_type", {30'd0, wave_type}, {30'd0, e_w});
    end
  end

  task automatic step(input logic [31:0] w, input bit f, input bit r);
    @(negedge clk);
    conf = w;
    flag = f;
    rst = r;
  endtask

  task automatic frame(input logic [31:0] fw, input logic [31:0] pw,
                       input logic [31:0] ww, input logic [31:0] tw,
                       input logic [4:0] fl);
    step(HEAD, fl[0], 1'b0);
    step(fw, fl[1], 1'b0);
    step(pw, fl[2], 1'b0);
    step(ww, fl[3], 1'b0);
    step(tw, fl[4], 1'b0);
  endtask

  task automatic do_reset();
    step(32'd0, 1'b0, 1'b1);
    step(32'd0, 1'b0, 1'b1);
    step(32'd0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    flag = 1'b0;
    conf = '0;

    // 1: reset state, then a good frame
    do_reset();
    chk("lit_rst_f", f_word, 32'd0);
    chk("lit_rst_en", {31'd0, dds_en}, 32'd0);
    frame(32'd1000, 32'd2048, 32'd2, TAIL, 5'b11111);
    step(32'd0, 1'b1, 1'b0);
    chk("lit1_set", {31'd0, set_flag}, 32'd1);
    chk("lit1_f", f_word, 32'd1000);
    chk("lit1_p", {20'd0, p_word}, 32'h800);
    chk("lit1_w", {30'd0, wave_type}, 32'd2);
    chk("lit1_en0", {31'd0, dds_en}, 32'd0);
    step(32'd0, 1'b1, 1'b0);
    chk("lit1_set0", {31'd0, set_flag}, 32'd0);
    chk("lit1_en1", {31'd0, dds_en}, 32'd1);

    // 2: bad trailer after reset
    do_reset();
    frame(32'd1000, 32'd2048, 32'd2, 32'd0, 5'b11111);
    step(32'd0, 1'b1, 1'b0);
    step(32'd0, 1'b1, 1'b0);
    chk("lit2_f", f_word, 32'd0);
    chk("lit2_en", {31'd0, dds_en}, 32'd0);

    // 3: flag low for whole frame, flag dropped in WAVE, then good
    frame(32'd7, 32'd7, 32'd3, TAIL, 5'b00000);
    frame(32'd9, 32'd9, 32'd3, TAIL, 5'b00111);
    step(32'd0, 1'b1, 1'b0);
    step(32'd0, 1'b1, 1'b0);
    chk("lit3_nocommit", f_word, 32'd0);
    frame(32'd1000, 32'd2048, 32'd2, TAIL, 5'b11111);
    step(32'd0, 1'b1, 1'b0);
    chk("lit3_f", f_word, 32'd1000);

    // 4: dds_en follows the work flag with one edge of lag
    step(32'd0, 1'b0, 1'b0);
    step(32'd0, 1'b0, 1'b0);
    chk("lit4_en0", {31'd0, dds_en}, 32'd0);
    chk("lit4_hold", f_word, 32'd1000);
    step(32'd0, 1'b1, 1'b0);
    step(32'd0, 1'b1, 1'b0);
    chk("lit4_en1", {31'd0, dds_en}, 32'd1);

    // 5: upper bits ignored, all-ones f_word is data
    frame(32'hFFFF_FFFF, 32'hFFFF_F123, 32'hFFFF_FFFD, TAIL, 5'b11111);
    step(32'd0, 1'b1, 1'b0);
    chk("lit5_f", f_word, 32'hFFFF_FFFF);
    chk("lit5_p", {20'd0, p_word}, 32'h123);
    chk("lit5_w", {30'd0, wave_type}, 32'd1);

    // 6: reset during PHASE of a follow-on frame
    step(HEAD, 1'b1, 1'b0);
    step(32'd55, 1'b1, 1'b0);
    step(32'd66, 1'b1, 1'b1);
    step(32'd1, 1'b1, 1'b0);
    chk("lit6_f", f_word, 32'd0);
    chk("lit6_w", {30'd0, wave_type}, 32'd0);
    step(TAIL, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(32'd0, 1'b1, 1'b0);
    chk("lit6_ign", f_word, 32'd0);
    chk("lit6_set", {31'd0, set_flag}, 32'd0);

    // random frames with corruption, flag drops and rare resets
    for (int k = 0; k < 400; k++) begin
      int gap;
      logic [31:0] wds[5];
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        logic [31:0] gw;
        gw = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        step(gw, $urandom_range(0, 9) != 0, $urandom_range(0, 99) == 0);
      end
      wds[0] = HEAD;
      wds[1] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      wds[2] = $urandom;
      wds[3] = $urandom;
      wds[4] = ($urandom_range(0, 4) == 0) ? $urandom : TAIL;
      for (int j = 0; j < 5; j++)
        step(wds[j], $urandom_range(0, 19) != 0,
             $urandom_range(0, 149) == 0);
    end
    for (int i = 0; i < 4; i++) step(32'd0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
